// File: rtl/serial_adder_pkg.sv
// Shared types and helpers for the multi-cycle serial adder.
package serial_adder_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRun  = 2'd1,
    StDone = 2'd2
  } state_e;

  // Ceiling log2; returns 0 for n <= 1.
  function automatic int unsigned clog2(input int unsigned n);
    int unsigned r;
    r = 0;
    while ((64'd1 << r) < 64'(n)) begin
      r++;
    end
    return r;
  endfunction

endpackage

// File: rtl/fa_slice.sv
// Combinational ripple of SLICE full-adder cells; c_msb is the carry into the top cell.
module fa_slice #(
  parameter int unsigned SLICE = 2
) (
  input  logic [SLICE-1:0] a,
  input  logic [SLICE-1:0] b,
  input  logic             ci,
  output logic [SLICE-1:0] s,
  output logic             co,
  output logic             c_msb
);

  logic [SLICE:0] c;

  assign c[0] = ci;

  for (genvar i = 0; i < SLICE; i++) begin : g_cell
    assign s[i]   = a[i] ^ b[i] ^ c[i];
    assign c[i+1] = (a[i] & b[i]) | (a[i] & c[i]) | (b[i] & c[i]);
  end

  assign co    = c[SLICE];
  assign c_msb = c[SLICE-1];

endmodule

// File: rtl/serial_adder.sv
// Serial adder: SLICE bits per clock, WIDTH/SLICE cycles per add, start/done handshake.
// Define SERIAL_ADDER_SUB_EN to add a 'sub' input selecting A - B.
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned SLICE = 2
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Ci,
`ifdef SERIAL_ADDER_SUB_EN
  input  logic             sub,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] Y,
  output logic             Co,
  output logic             ovf
);

  localparam int unsigned STEPS = WIDTH / SLICE;
  localparam int unsigned CntW  = (clog2(STEPS) < 1) ? 1 : clog2(STEPS);
  localparam logic [CntW-1:0] LastStep = CntW'(STEPS - 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             carry_q, carry_d;
  logic [CntW-1:0]  step_q, step_d;
  logic [WIDTH-1:0] y_q, y_d;
  logic             co_q, co_d;
  logic             ovf_q, ovf_d;

  logic             sub_w;
  logic [SLICE-1:0] slice_s;
  logic             slice_co;
  logic             slice_cmsb;
  logic [WIDTH-1:0] slice_ext;

`ifdef SERIAL_ADDER_SUB_EN
  assign sub_w = sub;
`else
  assign sub_w = 1'b0;
`endif

  fa_slice #(
    .SLICE(SLICE)
  ) u_fa_slice (
    .a    (a_q[SLICE-1:0]),
    .b    (b_q[SLICE-1:0]),
    .ci   (carry_q),
    .s    (slice_s),
    .co   (slice_co),
    .c_msb(slice_cmsb)
  );

  // Slice sum enters at the top of the result register.
  assign slice_ext = WIDTH'(slice_s) << (WIDTH - SLICE);

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    step_d  = step_q;
    y_d     = y_q;
    co_d    = co_q;
    ovf_d   = ovf_q;
    case (state_q)
      StIdle: begin
        if (start) begin
          a_d     = A;
          b_d     = sub_w ? ~B : B;
          carry_d = sub_w ? 1'b1 : Ci;
          step_d  = '0;
          state_d = StRun;
        end
      end
      StRun: begin
        a_d     = a_q >> SLICE;
        b_d     = b_q >> SLICE;
        sum_d   = (sum_q >> SLICE) | slice_ext;
        carry_d = slice_co;
        step_d  = step_q + CntW'(1);
        if (step_q == LastStep) begin
          y_d     = sum_d;
          co_d    = slice_co;
          ovf_d   = slice_cmsb ^ slice_co;
          state_d = StDone;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= StIdle;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      step_q  <= '0;
      y_q     <= '0;
      co_q    <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      step_q  <= step_d;
      y_q     <= y_d;
      co_q    <= co_d;
      ovf_q   <= ovf_d;
    end
  end

  assign busy = (state_q == StRun);
  assign done = (state_q == StDone);
  assign Y    = y_q;
  assign Co   = co_q;
  assign ovf  = ovf_q;

endmodule
